// File: rtl/fetch_prefetch_buffer.sv
// Instruction-fetch front end: owns the fetch PC, issues single-outstanding imem requests,
// buffers returned words in a small FIFO and handles redirects, drains and HLT.
module fetch_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [15:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [15:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [15:0]              redirect_pc,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [15:0]              id_instr,
  output logic [15:0]              id_pc_plus1,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fetch_halted
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] addr;
  } entry_t;

  state_t        state_q, state_d;
  logic [15:0]   fetch_pc;
  logic [15:0]   drain_addr;
  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count, count_after_pop, count_next;
  logic          push, pop, is_hlt;

  // Redirect cancels any same-cycle pop or push.
  assign pop             = (count != '0) && id_ready && !redirect;
  assign push            = (state_q == REQ) && imem_ack && !redirect;
  assign is_hlt          = (imem_rdata[15:12] == 4'hF);
  assign count_after_pop = count - (PW+1)'(pop);
  assign count_next      = count_after_pop + (PW+1)'(push);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (redirect || (count_after_pop < FULL)) state_d = REQ;
      REQ: begin
        if (redirect)           state_d = imem_ack ? REQ : DRAIN;
        else if (imem_ack) begin
          if (is_hlt)                   state_d = HALTED;
          else if (count_next < FULL)   state_d = REQ;
          else                          state_d = IDLE;
        end
      end
      DRAIN:  if (imem_ack) state_d = REQ;
      HALTED: if (redirect) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  // During DRAIN the abandoned request keeps its old address until it is acknowledged.
  always_comb begin
    imem_req     = 1'b0;
    imem_addr    = fetch_pc;
    fetch_halted = 1'b0;
    case (state_q)
      REQ:    imem_req = 1'b1;
      DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr;
      end
      HALTED: fetch_halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      drain_addr <= RESET_PC;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      if (state_q == REQ) drain_addr <= fetch_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 16'd1;
        wr_ptr   <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // NOTE: the entry storage is not reset; the count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= '{instr: imem_rdata, addr: fetch_pc};
  end

  assign head        = mem[rd_ptr];
  assign id_valid    = (count != '0);
  assign id_instr    = id_valid ? head.instr : 16'h0;
  assign id_pc_plus1 = id_valid ? head.addr + 16'd1 : 16'h0;
  assign fifo_count  = count;

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Self-checking bench for fetch_prefetch_buffer: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.
module tb_fetch_prefetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset, imem_req, imem_ack, redirect, id_ready, id_valid, fetch_halted;
  logic [15:0] imem_addr, imem_rdata, redirect_pc, id_instr, id_pc_plus1;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  fetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_ready(id_ready), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc_plus1(id_pc_plus1), .fifo_count(fifo_count),
    .fetch_halted(fetch_halted)
  );

  // Reference model: a queue of buffered words plus the outstanding-request picture.
  typedef struct {
    logic [15:0] instr;
    logic [15:0] addr;
  } entry_t;

  entry_t      q[$];
  logic [15:0] m_pc = RESET_PC, m_stale_addr = RESET_PC;
  bit          m_busy, m_stale, m_halted, hlt_popped;

  int          checks = 0, passed = 0;
  int          ready_pct, redir_pct, reset_pct, lat_lo, lat_hi, lat_left;
  int          redir_span = 0;
  bit          hlt_en = 1'b0;
  logic [15:0] hlt_addr = 16'h0005, redir_base = 16'h0, max_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] word(input logic [15:0] a);
    if (hlt_en && a == hlt_addr) return 16'hF000;
    return {4'(a % 16'd15), a[11:0] ^ 12'hA5C};
  endfunction

  task automatic knobs(input int rdy, input int rdr, input int rst, input int lo, input int hi);
    ready_pct = rdy; redir_pct = rdr; reset_pct = rst; lat_lo = lo; lat_hi = hi;
  endtask

  task automatic model_pop();
    if (q[0].instr == 16'hF000) hlt_popped = 1'b1;
    void'(q.pop_front());
  endtask

  task automatic model_step();
    bit pop_now;
    if (reset) begin
      q.delete();
      m_pc = RESET_PC; m_busy = 0; m_stale = 0; m_halted = 0;
      return;
    end
    pop_now = (q.size() != 0) && id_ready && !redirect;
    if (redirect) begin
      if (m_busy && !imem_ack) begin
        if (!m_stale) m_stale_addr = m_pc;
        m_stale = 1'b1;
      end else begin
        m_stale = 1'b0;
      end
      m_busy = 1'b1; m_halted = 1'b0;
      q.delete();
      m_pc = redirect_pc;
    end else if (m_busy && imem_ack) begin
      if (m_stale) m_stale = 1'b0;
      else begin
        if (pop_now) model_pop();
        q.push_back('{instr: imem_rdata, addr: m_pc});
        m_pc = m_pc + 16'd1;
        if (imem_rdata[15:12] == 4'hF) begin
          m_halted = 1'b1; m_busy = 1'b0;
        end else begin
          m_busy = (q.size() < DEPTH);
        end
      end
    end else begin
      if (pop_now) model_pop();
      if (!m_busy && !m_halted) m_busy = (q.size() < DEPTH);
    end
  endtask

  task automatic compare();
    logic [15:0] exp_instr, exp_pcp1;
    exp_instr = 16'h0; exp_pcp1 = 16'h0;
    if (q.size() != 0) begin
      exp_instr = q[0].instr;
      exp_pcp1  = q[0].addr + 16'd1;
    end
    check("imem_req",     32'(imem_req),     32'(m_busy));
    check("imem_addr",    32'(imem_addr),    32'(m_stale ? m_stale_addr : m_pc));
    check("id_valid",     32'(id_valid),     32'(q.size() != 0));
    check("fifo_count",   32'(fifo_count),   32'(q.size()));
    check("fetch_halted", 32'(fetch_halted), 32'(m_halted));
    check("id_instr",     32'(id_instr),     32'(exp_instr));
    check("id_pc_plus1",  32'(id_pc_plus1),  32'(exp_pcp1));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  // Random inputs; the memory responder acks after a random latency once a request is visible.
  task automatic drive_inputs();
    reset       = ($urandom_range(99, 0) < reset_pct);
    id_ready    = ($urandom_range(99, 0) < ready_pct);
    redirect    = ($urandom_range(99, 0) < redir_pct);
    redirect_pc = redir_base + 16'($urandom_range(redir_span, 0));
    imem_ack    = 1'b0;
    imem_rdata  = 16'($urandom);
    if (imem_req) begin
      if (imem_addr > max_addr) max_addr = imem_addr;
      if (lat_left == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = word(imem_addr);
        lat_left   = $urandom_range(lat_hi, lat_lo);
      end else begin
        lat_left--;
      end
    end
  endtask

  task automatic drive(input bit ack, input bit redir, input logic [15:0] rpc, input bit rdy);
    reset = 1'b0; imem_ack = ack; imem_rdata = word(imem_addr);
    redirect = redir; redirect_pc = rpc; id_ready = rdy;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset    = 1'b0;
    lat_left = lat_lo;
    max_addr = 16'h0;
  endtask

  initial begin
    // Stream: one-cycle memory latency, consumer always ready.
    knobs(100, 0, 0, 1, 1);
    do_reset();
    for (int i = 0; i < 24; i++) begin
      drive_inputs();
      tick();
      check("t1_count_le1", 32'(fifo_count <= 3'd1), 32'd1);
    end

    // Backpressure: four pushes then idle; a single pop restarts fetching at 4.
    knobs(0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive_inputs();
      tick();
    end
    check("t2_count_full", 32'(fifo_count), 32'd4);
    check("t2_req_idle",   32'(imem_req),   32'd0);
    ready_pct = 100;
    drive_inputs();
    tick();
    ready_pct = 0;
    check("t2_req_again",  32'(imem_req),   32'd1);
    check("t2_next_addr",  32'(imem_addr),  32'd4);

    // Late redirect while the request to 7 is pending.
    knobs(100, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 40 && !(imem_req && imem_addr == 16'd7); i++) begin
      drive_inputs();
      tick();
    end
    check("t3_reach_7", 32'(imem_addr), 32'd7);
    drive(1'b0, 1'b1, 16'h0040, 1'b1); tick();
    check("t3_hold_a", 32'(imem_addr), 32'd7);
    drive(1'b0, 1'b0, 16'h0, 1'b1); tick();
    check("t3_hold_b", 32'(imem_addr), 32'd7);
    drive(1'b0, 1'b0, 16'h0, 1'b1); tick();
    drive(1'b1, 1'b0, 16'h0, 1'b1); tick();
    check("t3_new_addr", 32'(imem_addr), 32'h40);
    check("t3_new_req",  32'(imem_req),  32'd1);
    check("t3_no_valid", 32'(id_valid),  32'd0);

    // Redirect, ack and pop all in one cycle with two entries buffered.
    knobs(0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 20 && !(imem_req && fifo_count == 3'd2); i++) begin
      drive_inputs();
      tick();
    end
    check("t4_reach_2", 32'(fifo_count), 32'd2);
    drive(1'b1, 1'b1, 16'h1234, 1'b1); tick();
    check("t4_count",   32'(fifo_count), 32'd0);
    check("t4_valid",   32'(id_valid),   32'd0);
    check("t4_addr",    32'(imem_addr),  32'h1234);

    // HLT at address 5: delivered, nothing fetched after it, redirect resumes.
    hlt_en = 1'b1; hlt_addr = 16'h0005; hlt_popped = 1'b0;
    knobs(100, 0, 0, 0, 2);
    do_reset();
    for (int i = 0; i < 40; i++) begin
      drive_inputs();
      tick();
    end
    check("t5_halted",    32'(fetch_halted), 32'd1);
    check("t5_req_off",   32'(imem_req),     32'd0);
    check("t5_max_addr",  32'(max_addr),     32'd5);
    check("t5_delivered", 32'(hlt_popped),   32'd1);
    drive(1'b0, 1'b1, 16'h0020, 1'b1); tick();
    check("t5_resume",    32'(imem_addr),    32'h20);
    check("t5_unhalt",    32'(fetch_halted), 32'd0);
    hlt_en = 1'b0;

    // Wrap from FFFF to 0000, then reset in the middle of a request.
    knobs(0, 0, 0, 0, 0);
    do_reset();
    drive(1'b0, 1'b1, 16'hFFFF, 1'b0); tick();
    check("t6_addr_ffff", 32'(imem_addr), 32'hFFFF);
    drive(1'b1, 1'b0, 16'h0, 1'b0); tick();
    check("t6_addr_wrap", 32'(imem_addr),   32'h0);
    check("t6_pcp1",      32'(id_pc_plus1), 32'h0);
    check("t6_instr",     32'(id_instr),    32'(word(16'hFFFF)));
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_req",   32'(imem_req),   32'd0);
    check("t6_rst_count", 32'(fifo_count), 32'd0);

    // Random traffic near a HLT word, with occasional resets and redirects.
    hlt_en = 1'b1; hlt_addr = 16'h0011; redir_base = 16'h0; redir_span = 31;
    knobs(60, 8, 1, 0, 3);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive_inputs();
      tick();
    end

    // Random traffic across the whole address space.
    hlt_en = 1'b0; redir_span = 65535;
    knobs(50, 5, 1, 0, 2);
    for (int i = 0; i < 1500; i++) begin
      drive_inputs();
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
